// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared definitions for the PPU VRAM CPU-side port:
//   - PPU register indices decoded from CPU address bits [2:0]
//   - palette page marker (high six pointer bits of the palette range)
//   - pointer increment amounts selected by PPUCTRL bit 2
//   - access FSM state encoding
// ---------------------------------------------------------------------------
package ppu_pkg;

    localparam logic [2:0] REG_PPUSTATUS = 3'd2;
    localparam logic [2:0] REG_PPUADDR   = 3'd6;
    localparam logic [2:0] REG_PPUDATA   = 3'd7;

    localparam logic [5:0] PAL_HI = 6'h3F;

    localparam int INC_ONE = 1;
    localparam int INC_ROW = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_WAIT = 2'd2,
        RD_DONE = 2'd3
    } vram_state_e;

    // True when the top six pointer bits select the palette page.
    function automatic logic is_palette(input logic [5:0] hi_bits);
        return hi_bits == PAL_HI;
    endfunction

endpackage

// File: rtl/ppu_addr_latch.sv
// ---------------------------------------------------------------------------
// ppu_addr_latch
// Holds the PPU address state: temporary address t, live pointer v and the
// PPUADDR write toggle w.
//   clk, rst   : clock, synchronous active-low reset
//   addr_wr    : accepted PPUADDR write this cycle (byte in wdata)
//   status_rd  : accepted PPUSTATUS read this cycle (clears the toggle)
//   inc_en     : advance v by 1 or 32 (selected by inc32)
//   inc32      : PPUCTRL bit 2
//   wdata      : CPU write data
//   v          : current VRAM pointer
// Only one of addr_wr / status_rd / inc_en is asserted at a time by the
// owning FSM; the priority below just makes that explicit.
// ---------------------------------------------------------------------------
module ppu_addr_latch
    import ppu_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_wr,
    input  logic              status_rd,
    input  logic              inc_en,
    input  logic              inc32,
    input  logic [7:0]        wdata,
    output logic [ADDR_W-1:0] v
);

    logic [ADDR_W-1:0] t_q, t_d;
    logic [ADDR_W-1:0] v_q, v_d;
    logic              w_q, w_d;
    logic [ADDR_W-1:0] inc_amt;

    always_comb begin
        t_d     = t_q;
        v_d     = v_q;
        w_d     = w_q;
        inc_amt = inc32 ? ADDR_W'(INC_ROW) : ADDR_W'(INC_ONE);

        if (addr_wr) begin
            if (!w_q) begin
                // First write: high pointer bits only, low byte of t kept.
                t_d[ADDR_W-1:8] = wdata[ADDR_W-9:0];
                w_d             = 1'b1;
            end else begin
                // Second write: complete t and copy it into v in one step.
                t_d[7:0] = wdata;
                v_d      = {t_q[ADDR_W-1:8], wdata};
                w_d      = 1'b0;
            end
        end else if (status_rd) begin
            w_d = 1'b0;
        end else if (inc_en) begin
            // Natural wrap at ADDR_W bits gives the modulo increment.
            v_d = v_q + inc_amt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            t_q <= '0;
            v_q <= '0;
            w_q <= 1'b0;
        end else begin
            t_q <= t_d;
            v_q <= v_d;
            w_q <= w_d;
        end
    end

    assign v = v_q;

    // Write-data bits above the pointer width are never stored.
    if (ADDR_W < 16) begin : g_unused_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^wdata[7:ADDR_W-8];
    end

endmodule

// File: rtl/ppu_vram_port.sv
// ---------------------------------------------------------------------------
// ppu_vram_port
// CPU-facing initiator for the PPU memory's CPU-side port. Decodes accesses
// to PPUSTATUS ($2002), PPUADDR ($2006) and PPUDATA ($2007), keeps the
// PPUDATA read buffer and sequences single accesses into the PPU memory.
//
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   reg_sel           : PPU register index (CPU address bits [2:0])
//   reg_wr, reg_rd    : single-cycle CPU strobes (write wins if both)
//   reg_wdata         : CPU write data
//   inc32             : pointer increment 32 when 1, else 1
//   reg_rdata         : PPUDATA read result, qualified by reg_rdata_valid
//   busy              : access in flight; strobes are dropped while high
//   vram_cpu_addr     : memory address, zero-extended pointer
//   vram_cpu_data_in  : memory write data
//   vram_write_en     : memory write enable (only in WR)
//   vram_cpu_data_out : registered read data from memory
//
// Parameters: ADDR_W pointer width, RD_LAT memory read latency in edges.
// Build option: VRAM_PORT_PAL_BYPASS_EN - palette-page reads return memory
// data directly instead of the previous buffer content.
// ---------------------------------------------------------------------------
module ppu_vram_port
    import ppu_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  reg_sel,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [7:0]  reg_wdata,
    input  logic        inc32,
    output logic [7:0]  reg_rdata,
    output logic        reg_rdata_valid,
    output logic        busy,
    output logic [15:0] vram_cpu_addr,
    output logic [7:0]  vram_cpu_data_in,
    output logic        vram_write_en,
    input  logic [7:0]  vram_cpu_data_out
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    vram_state_e       state_q, state_d;
    logic [CNT_W-1:0]  lat_q, lat_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rbuf_q, rbuf_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              valid_q, valid_d;

    logic              addr_wr;
    logic              status_rd;
    logic              inc_en;
    logic              pal_bypass;
    logic              addr_active;
    logic [ADDR_W-1:0] v;

    ppu_addr_latch #(
        .ADDR_W (ADDR_W)
    ) u_addr_latch (
        .clk       (clk),
        .rst       (rst),
        .addr_wr   (addr_wr),
        .status_rd (status_rd),
        .inc_en    (inc_en),
        .inc32     (inc32),
        .wdata     (reg_wdata),
        .v         (v)
    );

`ifdef VRAM_PORT_PAL_BYPASS_EN
    assign pal_bypass = is_palette(v[ADDR_W-1 -: 6]);
`else
    assign pal_bypass = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
        rdata_d   = rdata_q;
        valid_d   = 1'b0;
        addr_wr   = 1'b0;
        status_rd = 1'b0;
        inc_en    = 1'b0;

        case (state_q)
            IDLE: begin
                // A write strobe shadows a simultaneous read strobe.
                if (reg_wr) begin
                    if (reg_sel == REG_PPUADDR) begin
                        addr_wr = 1'b1;
                    end else if (reg_sel == REG_PPUDATA) begin
                        wdata_d = reg_wdata;
                        state_d = WR;
                    end
                end else if (reg_rd) begin
                    if (reg_sel == REG_PPUSTATUS) begin
                        status_rd = 1'b1;
                    end else if (reg_sel == REG_PPUDATA) begin
                        lat_d   = CNT_W'(RD_LAT - 1);
                        state_d = RD_WAIT;
                    end
                end
            end
            WR: begin
                inc_en  = 1'b1;
                state_d = IDLE;
            end
            RD_WAIT: begin
                // Hold the address for RD_LAT cycles so the memory's
                // registered output reflects v by the time RD_DONE samples.
                if (lat_q == '0) begin
                    state_d = RD_DONE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RD_DONE: begin
                valid_d = 1'b1;
                rdata_d = pal_bypass ? vram_cpu_data_out : rbuf_q;
                rbuf_d  = vram_cpu_data_out;
                inc_en  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            wdata_q <= 8'h00;
            rbuf_q  <= 8'h00;
            rdata_q <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    // The address is only presented while an access is in flight.
    assign addr_active = (state_q != IDLE);

    for (genvar gi = 0; gi < 16; gi++) begin : g_addr
        if (gi < ADDR_W) begin : g_ptr_bit
            assign vram_cpu_addr[gi] = addr_active & v[gi];
        end else begin : g_zero_bit
            assign vram_cpu_addr[gi] = 1'b0;
        end
    end

    assign vram_write_en    = (state_q == WR);
    assign vram_cpu_data_in = vram_write_en ? wdata_q : 8'h00;
    assign busy             = addr_active;
    assign reg_rdata        = rdata_q;
    assign reg_rdata_valid  = valid_q;

endmodule

// File: tb/tb_ppu_vram_port.sv
`timescale 1ns/1ps
module tb_ppu_vram_port;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  reg_sel;
    logic        reg_wr, reg_rd;
    logic [7:0]  reg_wdata;
    logic        inc32;
    logic [7:0]  reg_rdata;
    logic        reg_rdata_valid;
    logic        busy;
    logic [15:0] vram_cpu_addr;
    logic [7:0]  vram_cpu_data_in;
    logic        vram_write_en;
    logic [7:0]  vram_cpu_data_out;

    ppu_vram_port #(.ADDR_W(14), .RD_LAT(RD_LAT)) dut (
        .clk               (clk),
        .rst               (rst),
        .reg_sel           (reg_sel),
        .reg_wr            (reg_wr),
        .reg_rd            (reg_rd),
        .reg_wdata         (reg_wdata),
        .inc32             (inc32),
        .reg_rdata         (reg_rdata),
        .reg_rdata_valid   (reg_rdata_valid),
        .busy              (busy),
        .vram_cpu_addr     (vram_cpu_addr),
        .vram_cpu_data_in  (vram_cpu_data_in),
        .vram_write_en     (vram_write_en),
        .vram_cpu_data_out (vram_cpu_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- PPU memory stand-in (registered read) ----------------
    byte unsigned ram [16384];
    byte unsigned pipe [RD_LAT];
    logic         pl_en = 1'b0;
    logic [13:0]  pl_addr = '0;
    byte unsigned pl_data = 0;

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (vram_write_en) ram[vram_cpu_addr[13:0]] <= vram_cpu_data_in;
        pipe[0] <= ram[vram_cpu_addr[13:0]];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign vram_cpu_data_out = pipe[RD_LAT-1];

    // ---------------- reference model ----------------
    typedef struct { int addr; int data; int cyc; } wr_exp_t;
    typedef struct { int data; int cyc; } rd_exp_t;
    wr_exp_t wr_q [$];
    rd_exp_t rd_q [$];

    byte unsigned ref_mem [16384];
    int mv, mt, mw, mbuf;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic flag(input string name, input int act);
        n_checks++;
        $display("FAIL %s: actual=0x%0h required=no event (cycle %0d)", name, act, cyc);
    endtask

    task automatic model_reset();
        mv = 0; mt = 0; mw = 0; mbuf = 0;
    endtask

    // Applies one strobe (sampled in cycle c) to the model.
    task automatic model_step(input bit wr, input bit rd, input int sel, input int d,
                              input int c, output bit exp_busy);
        int inc;
        int exp_data;
        bit bypass;
        inc = inc32 ? 32 : 1;
        exp_busy = 1'b0;
        if (wr) begin
            if (sel == 6) begin
                if (mw == 0) begin
                    mt = (mt & 'hFF) | ((d & 'h3F) << 8);
                    mw = 1;
                end else begin
                    mt = (mt & 'h3F00) | d;
                    mv = mt;
                    mw = 0;
                end
            end else if (sel == 7) begin
                wr_q.push_back('{addr: mv, data: d, cyc: c + 1});
                ref_mem[mv] = byte'(d);
                mv = (mv + inc) % 16384;
                exp_busy = 1'b1;
            end
        end else if (rd) begin
            if (sel == 2) begin
                mw = 0;
            end else if (sel == 7) begin
`ifdef VRAM_PORT_PAL_BYPASS_EN
                bypass = (mv >= 'h3F00);
`else
                bypass = 1'b0;
`endif
                exp_data = bypass ? int'(ref_mem[mv]) : mbuf;
                mbuf = ref_mem[mv];
                rd_q.push_back('{data: exp_data, cyc: c + 2 + RD_LAT});
                mv = (mv + inc) % 16384;
                exp_busy = 1'b1;
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        wr_exp_t we;
        rd_exp_t re;
        if (vram_write_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                flag("unexpected_write", int'(vram_cpu_addr));
            end else begin
                we = wr_q.pop_front();
                check("wr_addr", int'(vram_cpu_addr), we.addr);
                check("wr_data", int'(vram_cpu_data_in), we.data);
                check("wr_cycle", cyc, we.cyc);
            end
        end
        if (reg_rdata_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                flag("unexpected_valid", int'(reg_rdata));
            end else begin
                re = rd_q.pop_front();
                check("rd_data", int'(reg_rdata), re.data);
                check("rd_cycle", cyc, re.cyc);
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic issue(input bit wr, input bit rd, input logic [2:0] sel,
                         input logic [7:0] d, input bit model_it);
        bit exp_busy;
        exp_busy = 1'b0;
        reg_wr = wr; reg_rd = rd; reg_sel = sel; reg_wdata = d;
        if (model_it) model_step(wr, rd, int'(sel), int'(d), cyc, exp_busy);
        @(negedge clk);
        reg_wr = 1'b0; reg_rd = 1'b0;
        if (model_it) check("busy", int'(busy), int'(exp_busy));
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (busy === 1'b0) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) flag("idle_timeout", int'(busy));
    endtask

    task automatic do_op(input bit wr, input bit rd, input logic [2:0] sel, input logic [7:0] d);
        issue(wr, rd, sel, d, 1'b1);
        wait_idle();
    endtask

    task automatic preload(input int addr, input int data);
        pl_en = 1'b1; pl_addr = 14'(addr); pl_data = byte'(data);
        ref_mem[addr] = byte'(data);
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rdata"}, int'(reg_rdata), 0);
        check({tag, "_valid"}, int'(reg_rdata_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_addr"}, int'(vram_cpu_addr), 0);
        check({tag, "_din"}, int'(vram_cpu_data_in), 0);
        check({tag, "_we"}, int'(vram_write_en), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int kind;
        int hi;
        reg_sel = 3'd0; reg_wr = 1'b0; reg_rd = 1'b0; reg_wdata = 8'h00; inc32 = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_zero("reset");

        preload('h2000, 'h11);
        preload('h2001, 'h22);
        preload('h3F00, 'h0F);
        for (int i = 2; i < 128; i++) preload('h2000 + i, int'($urandom_range(0, 255)));

        // PPUADDR pair then PPUDATA writes at 0x2108 and 0x2109
        do_op(1, 0, 3'd6, 8'h21);
        do_op(1, 0, 3'd6, 8'h08);
        do_op(1, 0, 3'd7, 8'h5A);
        do_op(1, 0, 3'd7, 8'hC3);

        // Buffered reads at 0x2000/0x2001: 0x00 then 0x11
        do_op(1, 0, 3'd6, 8'h20);
        do_op(1, 0, 3'd6, 8'h00);
        do_op(0, 1, 3'd7, 8'h00);
        do_op(0, 1, 3'd7, 8'h00);

        // Increment by 32 wraps 0x3FE0 -> 0x0000
        inc32 = 1'b1;
        do_op(1, 0, 3'd6, 8'h3F);
        do_op(1, 0, 3'd6, 8'hE0);
        do_op(1, 0, 3'd7, 8'hA5);
        do_op(1, 0, 3'd7, 8'h5C);
        inc32 = 1'b0;

        // Status read clears the toggle between PPUADDR writes
        do_op(1, 0, 3'd6, 8'h3F);
        do_op(0, 1, 3'd2, 8'h00);
        do_op(1, 0, 3'd6, 8'h10);
        do_op(1, 0, 3'd7, 8'h77);
        do_op(1, 0, 3'd6, 8'h55);
        do_op(1, 0, 3'd7, 8'h66);

        // Write while busy is dropped; simultaneous rd+wr performs the write
        do_op(1, 0, 3'd6, 8'h20);
        do_op(1, 0, 3'd6, 8'h05);
        issue(0, 1, 3'd7, 8'h00, 1'b1);
        issue(1, 0, 3'd7, 8'hEE, 1'b0);
        wait_idle();
        do_op(1, 1, 3'd7, 8'h99);

        // Reset while the read is in RD_WAIT
        do_op(1, 0, 3'd6, 8'h20);
        do_op(1, 0, 3'd6, 8'h01);
        issue(0, 1, 3'd7, 8'h00, 1'b1);
        rst = 1'b0;
        rd_q.delete();
        model_reset();
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_valid_after_reset", int'(reg_rdata_valid), 0);
        end

        // Palette-page reads
        do_op(1, 0, 3'd6, 8'h3F);
        do_op(1, 0, 3'd6, 8'h00);
        do_op(0, 1, 3'd7, 8'h00);
        do_op(0, 1, 3'd7, 8'h00);

        // Randomised traffic
        for (int n = 0; n < 250; n++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1: begin
                    if (mw == 0) begin
                        case ($urandom_range(0, 3))
                            0: hi = 'h20;
                            1: hi = 'h21;
                            2: hi = 'h3F;
                            default: hi = int'($urandom_range(0, 255));
                        endcase
                        do_op(1, 0, 3'd6, 8'(hi));
                    end else begin
                        do_op(1, 0, 3'd6, 8'($urandom_range(0, 255)));
                    end
                end
                2: do_op(0, 1, 3'd2, 8'h00);
                3, 4: do_op(1, ($urandom_range(0, 3) == 0), 3'd7, 8'($urandom_range(0, 255)));
                5, 6, 7: do_op(0, 1, 3'd7, 8'h00);
                8: begin
                    if ($urandom_range(0, 1) == 0)
                        do_op(1, 0, 3'($urandom_range(3, 5)), 8'($urandom_range(0, 255)));
                    else
                        do_op(0, 1, 3'($urandom_range(0, 1)), 8'h00);
                end
                default: inc32 = ~inc32;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        check("pending_writes", wr_q.size(), 0);
        check("pending_reads", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ppu_vram_port.md
Name: ppu_vram_port

Overview:
CPU-facing initiator for the PPU VRAM memory's CPU-side port.
- Decodes PPU register accesses to PPUSTATUS ($2002), PPUADDR ($2006) and PPUDATA ($2007).
- Keeps the 14-bit VRAM address pointer, the PPUADDR write toggle and the PPUDATA read buffer.
- Drives vram_cpu_addr, vram_cpu_data_in and vram_write_en into the PPU memory, and captures vram_cpu_data_out from it.
- Sits between the CPU bus register decoder and the PPU memory block.

Parameters:
ADDR_W, 14, width of the VRAM pointer; upper bits of vram_cpu_addr are driven 0.
RD_LAT, 1, clock edges from the memory sampling the address to its registered read data being valid.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
reg_sel  input  3  PPU register index (CPU address bits [2:0])
reg_wr  input  1  single-cycle CPU write strobe
reg_rd  input  1  single-cycle CPU read strobe
reg_wdata  input  8  CPU write data
inc32  input  1  PPUCTRL bit 2: pointer increment is 32 when 1, otherwise 1
reg_rdata  output  8  PPUDATA read result
reg_rdata_valid  output  1  one-cycle pulse qualifying reg_rdata
busy  output  1  high while an access is in flight
vram_cpu_addr  output  16  address to memory, {2'b00, v}
vram_cpu_data_in  output  8  write data to memory
vram_write_en  output  1  memory write enable
vram_cpu_data_out  input  8  registered read data from memory

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst.
- Reset state: all outputs 0. Internal v=0, t=0, w=0, rbuf=0, FSM=IDLE.
- Reset mid-operation: any access in flight is abandoned. vram_write_en is low after that edge and no valid pulse is issued.
- Strobes are sampled only in IDLE (busy=0). Strobes while busy are dropped.
- If reg_wr and reg_rd arrive in the same cycle, the write wins and the read is dropped.
- PPUSTATUS read (sel=2, reg_rd): w<=0, no FSM activity. This block does not drive a PPUSTATUS response.
- PPUADDR write with w=0: t[13:8]<=wdata[5:0], w<=1.
- PPUADDR write with w=1: t[7:0]<=wdata, v<={t[13:8],wdata}, w<=0.
- PPUADDR and PPUSTATUS take effect in 1 cycle; busy stays 0.
- Writes to other sel values are ignored. Reads to sel values other than 2 and 7 are ignored.
- FSM states: IDLE, WR, RD_WAIT, RD_DONE.
- PPUDATA write:
  - IDLE->WR. In WR: vram_cpu_addr={2'b00,v}, vram_cpu_data_in=wdata, vram_write_en=1 for exactly one cycle.
  - On exit v<=v+inc, then WR->IDLE. Total 1 busy cycle.
- PPUDATA read:
  - IDLE->RD_WAIT with the address v presented. Stay RD_LAT cycles, then RD_DONE.
  - In RD_DONE: reg_rdata<=rbuf (previous buffer), reg_rdata_valid=1 for 1 cycle, rbuf<=vram_cpu_data_out, v<=v+inc, then ->IDLE.
  - Fixed 2+RD_LAT cycles from the strobe to the valid pulse.
- vram_write_en is 0 in every state except WR.
- Increment is modulo 2^ADDR_W: 3FFF+1=0000; 3FE0+32=0000.
- The write toggle w is not affected by PPUDATA accesses.

Optional Feature:
VRAM_PORT_PAL_BYPASS_EN.
- Defined: a PPUDATA read with v[13:8]==6'h3F returns vram_cpu_data_out directly in RD_DONE (unbuffered palette read). rbuf is still loaded with that same data. Timing is unchanged.
- Undefined: all reads are buffered identically, including the palette range.

Decomposition:
- Package ppu_pkg holds:
  - register indices REG_PPUSTATUS=3'd2, REG_PPUADDR=3'd6, REG_PPUDATA=3'd7
  - PAL_HI=6'h3F
  - the FSM state enum
  - increment constants 1 and 32
- One natural sub-module, ppu_addr_latch: holds t/v/w, performs the PPUADDR write sequence, the toggle clear and the pointer increment.
- The FSM and the read buffer stay in ppu_vram_port.

Test Plan:
- Write $2006=0x21, $2006=0x08, then $2007=0x5A (inc32=0) -> one vram_write_en cycle at vram_cpu_addr=0x2108 with data 0x5A; v becomes 0x2109.
- Preload mem[0x2000]=0x11 and mem[0x2001]=0x22; set v=0x2000, then do two $2007 reads -> first returns 0x00 (reset buffer), second returns 0x11; valid pulses 3 cycles after each strobe; v=0x2002.
- inc32=1, v=0x3FE0, $2007 write -> write lands at 0x3FE0, v wraps to 0x0000.
- Write $2006=0x3F, read $2002, write $2006=0x10 -> w was cleared by the status read, so t[13:8]=0x10 and v is unchanged.
- Issue a $2007 read and, 1 cycle later, a $2007 write while busy -> the write is dropped, no vram_write_en pulse, one valid pulse only; simultaneous rd+wr in IDLE -> write performed, no valid pulse.
- Assert rst=0 during RD_WAIT -> next cycle all outputs 0, no valid pulse. With VRAM_PORT_PAL_BYPASS_EN defined, a read at 0x3F00 holding 0x0F returns 0x0F on the first read.
